alu_arbiter: RTL and testbench

- Shares the single registered ALU datapath between two requesters: req0 (execute stage) and req1 (address/PC-increment helper).
- Round-robin arbitration, valid/ready handshakes on each requester's request and response channels.
- Sequences each operation through the ALU's one-edge result latency and returns the result and flags to the granted requester.
- Sits between the requesters and the ALU; it is the only driver of the ALU control and operand inputs.

---
 rtl/alu_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU between two requesters (optional lock: ALU_ARB_LOCK_EN).
// Latency: response valid in the third cycle after the request handshake; one operation per 4 cycles at best.
// Backpressure: a held response keeps the FSM in RESPOND, so both request channels stay not-ready until consumed.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6,
  parameter int MAX_OP = 23
) (
  input  logic              alu_clk,
  input  logic              alu_rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,

`ifdef ALU_ARB_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_rslt,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,

  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  input  logic [DATA_W-1:0] alu_rslt,
  input  logic [3:0]        alu_checks,

  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  // Opcode ceiling at the opcode width so the illegal-op compare is width-matched.
  localparam logic [CTRL_W-1:0] MAX_OP_C = CTRL_W'(MAX_OP);

  state_t              r_state;
  logic                r_ptr;      // requester favoured when both are valid
  logic                r_owner;    // requester whose operation is in flight
  logic                r_rsp0_vld;
  logic                r_rsp1_vld;
  logic [DATA_W-1:0]   r_rsp_rslt;
  logic [3:0]          r_rsp_flags;
  logic                r_rsp_err;
  logic [CTRL_W-1:0]   r_alu_ctrl;
  logic [DATA_W-1:0]   r_alu_in_1;
  logic [DATA_W-1:0]   r_alu_in_2;
  logic                r_busy;
`ifdef ALU_ARB_LOCK_EN
  logic                r_lock_hold; // owner keeps the ALU for the next IDLE cycle
`endif

  logic                w_any_vld;
  logic                w_sel;
  logic                w_grant;
  logic                w_rsp_hs;
  logic [CTRL_W-1:0]   w_ctrl;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;

  // Requester selection: a lone valid requester wins, otherwise the pointer decides; a held lock overrides both.
  always_comb begin
    w_any_vld = req0_valid | req1_valid;
    w_sel     = 1'b0;
    if (req0_valid && !req1_valid) begin
      w_sel = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      w_sel = 1'b1;
    end else begin
      w_sel = r_ptr;
    end
`ifdef ALU_ARB_LOCK_EN
    // A lock only matters if the owner actually turns up again in that first IDLE cycle.
    if (r_lock_hold && (r_owner ? req1_valid : req0_valid)) begin
      w_sel = r_owner;
    end
`endif
  end

  // Grant only from IDLE, and never in a reset cycle so no requester believes an abandoned op was taken.
  always_comb begin
    w_grant = (r_state == S_IDLE) && !alu_rst && w_any_vld;
    w_ctrl  = w_sel ? req1_ctrl : req0_ctrl;
    w_a     = w_sel ? req1_a    : req0_a;
    w_b     = w_sel ? req1_b    : req0_b;
  end

  assign req0_ready = w_grant && !w_sel;
  assign req1_ready = w_grant &&  w_sel;

  // Response handshake on whichever channel currently holds the result.
  assign w_rsp_hs = (r_rsp0_vld && rsp0_ready) || (r_rsp1_vld && rsp1_ready);

  // Operation sequencer: IDLE -> ISSUE -> CAPTURE -> RESPOND, all outputs registered.
  always_ff @(posedge alu_clk) begin
    if (alu_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_rsp0_vld  <= 1'b0;
      r_rsp1_vld  <= 1'b0;
      r_rsp_rslt  <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= 1'b0;
      r_alu_ctrl  <= '0;
      r_alu_in_1  <= '0;
      r_alu_in_2  <= '0;
      r_busy      <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      r_lock_hold <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef ALU_ARB_LOCK_EN
          // The lock grants precedence for one IDLE cycle only.
          r_lock_hold <= 1'b0;
`endif
          // ALU inputs are only rewritten on a grant; otherwise they keep the last operation.
          if (w_grant) begin
            r_alu_ctrl <= w_ctrl;
            r_alu_in_1 <= w_a;
            r_alu_in_2 <= w_b;
            r_owner    <= w_sel;
            r_ptr      <= ~w_sel;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Operands held a full cycle; the ALU registers its result on the closing edge.
          r_state <= S_CAPTURE;
        end

        S_CAPTURE: begin
          // Illegal opcodes still ran on the ALU; its result and flags pass through, error is flagged here.
          r_rsp_rslt  <= alu_rslt;
          r_rsp_flags <= alu_checks;
          r_rsp_err   <= (r_alu_ctrl > MAX_OP_C);
          r_rsp0_vld  <= ~r_owner;
          r_rsp1_vld  <= r_owner;
          r_state     <= S_RESPOND;
        end

        S_RESPOND: begin
          // Result stays put until the owner takes it; no timeout.
          if (w_rsp_hs) begin
            r_rsp0_vld <= 1'b0;
            r_rsp1_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
`ifdef ALU_ARB_LOCK_EN
            r_lock_hold <= r_owner ? req1_lock : req0_lock;
`endif
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rsp0_valid = r_rsp0_vld;
  assign rsp1_valid = r_rsp1_vld;
  assign rsp_rslt   = r_rsp_rslt;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_err    = r_rsp_err;
  assign alu_ctrl   = r_alu_ctrl;
  assign alu_in_1   = r_alu_in_1;
  assign alu_in_2   = r_alu_in_2;
  assign busy       = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small one-edge-latency ALU stand-in.
// Flags from the stand-in ALU are {N, Z, C, 0}; illegal opcodes (> 23) return 0.
// Inputs are driven and outputs sampled 1-2 time units after the rising edge.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [5:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_lock = 1'b0, req1_lock = 1'b0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_rslt;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [5:0]  alu_ctrl;
  logic [31:0] alu_in_1, alu_in_2;
  logic [31:0] alu_rslt = '0;
  logic [3:0]  alu_checks = '0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .alu_clk    (clk),
    .alu_rst    (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_ctrl  (req0_ctrl),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_ctrl  (req1_ctrl),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
`ifdef ALU_ARB_LOCK_EN
    .req0_lock  (req0_lock),
    .req1_lock  (req1_lock),
`endif
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_rslt   (rsp_rslt),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .alu_ctrl   (alu_ctrl),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .alu_rslt   (alu_rslt),
    .alu_checks (alu_checks),
    .busy       (busy)
  );

  // Stand-in ALU: 0 ADD, 1 SUB, 4 INC(a), other legal codes XOR, codes above 23 give 0.
  function automatic logic [35:0] alu_f(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        cy;
    s = '0; cy = 1'b0;
    if (c == 6'd0) begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32]; end
    else if (c == 6'd1) begin r = a - b; end
    else if (c == 6'd4) begin s = {1'b0, a} + 33'd1; r = s[31:0]; cy = s[32]; end
    else if (c <= 6'd23) begin r = a ^ b; end
    else begin r = '0; end
    return {r[31], (r == 32'd0), cy, 1'b0, r};
  endfunction

  always @(posedge clk) {alu_checks, alu_rslt} <= alu_f(alu_ctrl, alu_in_1, alu_in_2);

  // Runs one operation on requester 'who' with immediate response acceptance.
  // lat counts rising edges from the handshake edge (inclusive) to rsp valid; 20 means timeout, -1 never granted.
  task automatic do_op(input logic who, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f, output logic e,
                       output int lat, output logic other_seen);
    int n;
    r = '0; f = '0; e = 1'b0; lat = 0; other_seen = 1'b0;
    if (!who) begin req0_valid = 1'b1; req0_ctrl = c; req0_a = a; req0_b = b; end
    else      begin req1_valid = 1'b1; req1_ctrl = c; req1_a = a; req1_b = b; end
    #1;
    n = 0;
    while (!(who ? req1_ready : req0_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      req0_valid = 1'b0; req1_valid = 1'b0; lat = -1;
      return;
    end
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 1) begin
        if (!who) req0_valid = 1'b0; else req1_valid = 1'b0;
      end
      if (who ? rsp0_valid : rsp1_valid) other_seen = 1'b1;
    end while (!(who ? rsp1_valid : rsp0_valid) && lat < 20);
    r = rsp_rslt; f = rsp_flags; e = rsp_err;
    if (!who) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
      bad++; $display("FAIL reset_hs got=%b want=00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
    end
    total++;
    if ({rsp_rslt, rsp_flags, rsp_err} !== 37'd0) begin
      bad++; $display("FAIL reset_rsp got=%h/%h/%b want=0", rsp_rslt, rsp_flags, rsp_err);
    end
    total++;
    if ({alu_ctrl, alu_in_1, alu_in_2} !== 70'd0) begin
      bad++; $display("FAIL reset_alu got=%h/%h/%h want=0", alu_ctrl, alu_in_1, alu_in_2);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single;
    logic [31:0] r; logic [3:0] f; logic e, o; int lat;
    do_op(1'b0, 6'd0, 32'd5, 32'd7, r, f, e, lat, o);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL single_latency got=%0d want=3", lat); end
    total++;
    if (r !== 32'd12) begin bad++; $display("FAIL single_rslt got=%0d want=12", r); end
    total++;
    if ({e, f} !== 5'b0) begin bad++; $display("FAIL single_err_flags got=%b want=00000", {e, f}); end
    total++;
    if (o !== 1'b0) begin bad++; $display("FAIL single_rsp1_quiet got=%b want=0", o); end
    total++;
    if ({busy, rsp0_valid} !== 2'b00) begin bad++; $display("FAIL single_idle got=%b want=00", {busy, rsp0_valid}); end
  endtask

  task automatic test_contention;
    int ng, nr, cyc;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    req0_ctrl = 6'd0; req0_a = 32'd1; req0_b = 32'd1;
    req1_ctrl = 6'd4; req1_a = 32'd9; req1_b = 32'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    ng = 0; nr = 0; cyc = 0;
    while (nr < 4 && cyc < 60) begin
      if ((req0_ready || req1_ready) && ng < 4) begin
        total++;
        if ({req1_ready, req0_ready} !== (ng[0] ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL contention_grant%0d got=%b want=%b", ng, {req1_ready, req0_ready}, (ng[0] ? 2'b10 : 2'b01));
        end
        ng++;
      end
      if (rsp0_valid || rsp1_valid) begin
        total++;
        if ({rsp1_valid, rsp0_valid, rsp_rslt} !== (nr[0] ? {2'b10, 32'd10} : {2'b01, 32'd2})) begin
          bad++; $display("FAIL contention_rsp%0d got=%b/%0d want=%s", nr, {rsp1_valid, rsp0_valid}, rsp_rslt, nr[0] ? "10/10" : "01/2");
        end
        nr++;
        if (nr == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      @(posedge clk); #1; cyc++;
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    total++;
    if (nr !== 4 || ng !== 4) begin bad++; $display("FAIL contention_count got=%0d/%0d want=4/4", ng, nr); end
  endtask

  task automatic test_back_pressure;
    int n;
    logic [31:0] held;
    req1_valid = 1'b1; req1_ctrl = 6'd4; req1_a = 32'd41; req1_b = 32'd0;
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    // Both requesters now knock while the result is held.
    req0_valid = 1'b1; req0_ctrl = 6'd1; req0_a = 32'd3; req0_b = 32'd1;
    req1_ctrl = 6'd0; req1_a = 32'd8; req1_b = 32'd8;
    n = 0;
    while (!rsp1_valid && n < 20) begin @(posedge clk); #1; n++; end
    held = rsp_rslt;
    total++;
    if (held !== 32'd42) begin bad++; $display("FAIL bp_rslt got=%0d want=42", held); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({rsp1_valid, rsp0_valid, busy, req0_ready, req1_ready, rsp_rslt} !== {5'b10100, 32'd42}) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%0d want=10100/42", i, {rsp1_valid, rsp0_valid, busy, req0_ready, req1_ready}, rsp_rslt);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    total++;
    if ({busy, rsp1_valid} !== 2'b00) begin bad++; $display("FAIL bp_release got=%b want=00", {busy, rsp1_valid}); end
  endtask

  task automatic test_illegal;
    logic [31:0] r; logic [3:0] f; logic e, o; int lat;
    do_op(1'b0, 6'd30, 32'd3, 32'd4, r, f, e, lat, o);
    total++;
    if ({r, e} !== {32'd0, 1'b1}) begin bad++; $display("FAIL illegal30 got=%0d err=%b want=0 err=1", r, e); end
    total++;
    if (f !== 4'b0100) begin bad++; $display("FAIL illegal30_flags got=%b want=0100", f); end
    do_op(1'b1, 6'd23, 32'd6, 32'd3, r, f, e, lat, o);
    total++;
    if ({r, e} !== {32'd5, 1'b0}) begin bad++; $display("FAIL legal23 got=%0d err=%b want=5 err=0", r, e); end
    do_op(1'b0, 6'd24, 32'd6, 32'd3, r, f, e, lat, o);
    total++;
    if ({r, e, f} !== {32'd0, 1'b1, 4'b0100}) begin bad++; $display("FAIL illegal24 got=%0d err=%b f=%b want=0 1 0100", r, e, f); end
  endtask

  task automatic test_reset_midop;
    logic [31:0] r; logic [3:0] f; logic e, o; int lat;
    logic seen;
    req0_valid = 1'b1; req0_ctrl = 6'd0; req0_a = 32'd100; req0_b = 32'd1;
    #1;
    @(posedge clk); #1;          // handshake edge, now ISSUE
    req0_valid = 1'b0;
    @(posedge clk); #1;          // CAPTURE
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midop_busy got=%b want=1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
      bad++; $display("FAIL midop_reset got=%b want=00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
    end
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (rsp0_valid || rsp1_valid || busy) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midop_abandoned got=%b want=0", seen); end
    // Pointer was moved to 1 by the abandoned grant; reset must bring it back to 0.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL midop_ptr got=%b want=10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    do_op(1'b1, 6'd4, 32'd7, 32'd0, r, f, e, lat, o);
    total++;
    if (lat !== 3 || r !== 32'd8) begin bad++; $display("FAIL midop_req1 got=lat%0d/%0d want=lat3/8", lat, r); end
  endtask

`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock;
    int ng, cyc;
    logic [1:0] g [3];
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    req0_ctrl = 6'd0; req0_a = 32'd2; req0_b = 32'd2;
    req1_ctrl = 6'd4; req1_a = 32'd0; req1_b = 32'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_lock = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    ng = 0; cyc = 0;
    while (ng < 3 && cyc < 60) begin
      if (req0_ready || req1_ready) begin
        g[ng] = {req1_ready, req0_ready};
        ng++;
        if (ng == 2) req0_lock = 1'b0;
        if (ng == 3) begin @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      @(posedge clk); #1; cyc++;
    end
    cyc = 0;
    while (busy && cyc < 20) begin @(posedge clk); #1; cyc++; end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    total++;
    if (ng !== 3) begin bad++; $display("FAIL lock_count got=%0d want=3", ng); end
    else begin
      total++;
      if ({g[0], g[1], g[2]} !== 6'b01_01_10) begin
        bad++; $display("FAIL lock_order got=%b %b %b want=01 01 10", g[0], g[1], g[2]);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_back_pressure;
    test_illegal;
    test_reset_midop;
`ifdef ALU_ARB_LOCK_EN
    test_lock;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
